// File: rtl/timer_cnt_ctrl_if.sv
// Control/status bundle between the APB timer register file and the
// counter controller. The register file drives the i_* fields; the counter
// controller returns the count, halt acknowledge and interrupt status.
interface timer_cnt_ctrl_if #(
  parameter int CNT_WIDTH = 64,
  parameter int DIV_WIDTH = 4
);
  logic                 i_timer_en;
  logic                 i_div_en;
  logic [DIV_WIDTH-1:0] i_div_val;
  logic                 i_halt_req;
  logic                 i_cnt_wr;
  logic [CNT_WIDTH-1:0] i_cnt_wdata;
  logic [CNT_WIDTH-1:0] i_cmp_val;
  logic                 i_int_en;
  logic                 i_int_clr;
  logic [CNT_WIDTH-1:0] o_cnt;
  logic                 o_halt_ack;
  logic                 o_int_st;
  logic                 o_tim_int;

  // Register-file side: supplies control, consumes status.
  modport master (
    output i_timer_en, i_div_en, i_div_val, i_halt_req, i_cnt_wr,
           i_cnt_wdata, i_cmp_val, i_int_en, i_int_clr,
    input  o_cnt, o_halt_ack, o_int_st, o_tim_int
  );

  // Counter-controller side.
  modport slave (
    input  i_timer_en, i_div_en, i_div_val, i_halt_req, i_cnt_wr,
           i_cnt_wdata, i_cmp_val, i_int_en, i_int_clr,
    output o_cnt, o_halt_ack, o_int_st, o_tim_int
  );
endinterface

// File: rtl/timer_cnt_ctrl.sv
// Counter controller for the APB timer. Sequences the up-counter through
// IDLE/RUN/HALT, produces the divided count-enable tick, and keeps a sticky
// compare-match status that is gated with the interrupt enable.
module timer_cnt_ctrl #(
  parameter int CNT_WIDTH = 64,
  parameter int DIV_WIDTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  timer_cnt_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           div_cnt_q, div_cnt_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 int_st_q, int_st_d;

  logic                 cnt_en;
  logic                 div_bypass;
  logic [7:0]           div_target;
  logic                 div_hit;
  logic                 tick;
  logic                 match;

  // Terminal value of the 8-bit divider counter for a given select.
  // Selects above 8 saturate to a 256-cycle period.
  function automatic logic [7:0] div_terminal(input logic [DIV_WIDTH-1:0] sel);
    logic [15:0] span;
    if (int'(sel) >= 8) begin
      span = 16'd256;
    end else begin
      span = 16'd1 << sel;
    end
    return 8'(span - 16'd1);
  endfunction

  // Next-state logic: dropping the enable wins over a halt request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_timer_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!bus.i_timer_en)    state_d = ST_IDLE;
        else if (bus.i_halt_req) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (!bus.i_timer_en)     state_d = ST_IDLE;
        else if (!bus.i_halt_req) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Count enable and divider: enable uses the live inputs so counting stops
  // in the same cycle the enable drops or a halt is requested.
  always_comb begin
    cnt_en     = (state_q == ST_RUN) && bus.i_timer_en && !bus.i_halt_req;
    div_bypass = !bus.i_div_en || (bus.i_div_val == '0);
    div_target = div_terminal(bus.i_div_val);
    div_hit    = (div_cnt_q == div_target);
    tick       = cnt_en && (div_bypass || div_hit);

    div_cnt_d = div_cnt_q;
    if ((state_q == ST_IDLE) || !bus.i_div_en) begin
      div_cnt_d = 8'd0;
    end else if (cnt_en && !div_bypass) begin
      div_cnt_d = div_hit ? 8'd0 : div_cnt_q + 8'd1;
    end
  end

  // Counter: a software write wins over a same-cycle tick; wrap is silent.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.i_cnt_wr) begin
      cnt_d = bus.i_cnt_wdata;
    end else if (tick) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Sticky match status from the registered count; a new match beats clear.
  always_comb begin
    match    = (cnt_q == bus.i_cmp_val);
    int_st_d = int_st_q;
    if (match) begin
      int_st_d = 1'b1;
    end else if (bus.i_int_clr) begin
      int_st_d = 1'b0;
    end
  end

  // State, divider, count and status registers with async reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= 8'd0;
      cnt_q     <= '0;
      int_st_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      cnt_q     <= cnt_d;
      int_st_q  <= int_st_d;
    end
  end

  assign bus.o_cnt      = cnt_q;
  assign bus.o_halt_ack = (state_q == ST_HALT);
  assign bus.o_int_st   = int_st_q;
  assign bus.o_tim_int  = int_st_q & bus.i_int_en;

endmodule

// File: tb/tb_timer_cnt_ctrl.sv
// Bench for timer_cnt_ctrl: directed scenarios followed by randomized
// segments, all compared each cycle against a behavioural model.
module tb_timer_cnt_ctrl;
  localparam int CW = 64;
  localparam int DW = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk = 1'b0;
  logic rst;

  timer_cnt_ctrl_if #(.CNT_WIDTH(CW), .DIV_WIDTH(DW)) bus ();

  timer_cnt_ctrl #(.CNT_WIDTH(CW), .DIV_WIDTH(DW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int          m_st;
  logic [63:0] m_cnt;
  int          m_phase;
  bit          m_int;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_cnt = '0; m_phase = 0; m_int = 0;
  endtask

  // Advance the model by one clock edge using the inputs held before the edge.
  task automatic model_edge();
    int  sel, period, nst;
    bit  cen, byp, tck, mt;
    sel    = (int'(bus.i_div_val) > 8) ? 8 : int'(bus.i_div_val);
    period = 1 << sel;
    byp    = !bus.i_div_en || (bus.i_div_val == 0);
    cen    = (m_st == M_RUN) && bus.i_timer_en && !bus.i_halt_req;
    tck    = cen && (byp || (m_phase == period - 1));
    mt     = (m_cnt == bus.i_cmp_val);
    nst    = m_st;
    if (m_st == M_IDLE) begin
      if (bus.i_timer_en) nst = M_RUN;
    end else if (!bus.i_timer_en) begin
      nst = M_IDLE;
    end else if (m_st == M_RUN && bus.i_halt_req) begin
      nst = M_HALT;
    end else if (m_st == M_HALT && !bus.i_halt_req) begin
      nst = M_RUN;
    end
    if (m_st == M_IDLE || !bus.i_div_en) m_phase = 0;
    else if (cen && !byp) m_phase = (m_phase + 1) % period;
    m_int = mt || (m_int && !bus.i_int_clr);
    if (bus.i_cnt_wr) m_cnt = bus.i_cnt_wdata;
    else if (tck) m_cnt = m_cnt + 64'd1;
    m_st = nst;
  endtask

  task automatic check_model();
    chk("cnt", bus.o_cnt, m_cnt);
    chk("halt_ack", 64'(bus.o_halt_ack), 64'(m_st == M_HALT));
    chk("int_st", 64'(bus.o_int_st), 64'(m_int));
    chk("tim_int", 64'(bus.o_tim_int), 64'(m_int && bus.i_int_en));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic write_cnt(input logic [63:0] v);
    bus.i_cnt_wr = 1'b1; bus.i_cnt_wdata = v;
    step();
    bus.i_cnt_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_timer_en = 0; bus.i_div_en = 0; bus.i_div_val = '0; bus.i_halt_req = 0;
    bus.i_cnt_wr = 0; bus.i_cnt_wdata = '0; bus.i_cmp_val = 64'hDEAD_BEEF_0000_0000;
    bus.i_int_en = 0; bus.i_int_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    rst = 1'b0;

    // Bypass count for 10 edges after entering RUN, then stop.
    bus.i_timer_en = 1;
    step();
    repeat (10) step();
    chk("bypass_10", bus.o_cnt, 64'd10);
    bus.i_timer_en = 0;
    step();
    step();
    chk("idle_hold", bus.o_cnt, 64'd10);

    // Divide by 4 for 16 edges.
    write_cnt(64'd0);
    bus.i_div_en = 1; bus.i_div_val = 4'd2; bus.i_timer_en = 1;
    step();
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("div4", bus.o_cnt, 64'(i >> 2));
    end
    bus.i_timer_en = 0;
    step();
    write_cnt(64'd0);

    // Select 12 saturates to a 256-cycle period.
    bus.i_div_val = 4'd12; bus.i_timer_en = 1;
    step();
    for (int i = 1; i <= 512; i++) begin
      step();
      if (i == 255 || i == 256 || i == 512) chk("div256", bus.o_cnt, 64'(i >> 8));
    end
    bus.i_timer_en = 0; bus.i_div_en = 0; bus.i_div_val = '0;
    step();

    // Wrap through all-ones, then a write colliding with a tick.
    write_cnt(64'hFFFF_FFFF_FFFF_FFFE);
    bus.i_timer_en = 1;
    step();
    chk("wrap_fe", bus.o_cnt, 64'hFFFF_FFFF_FFFF_FFFE);
    step(); chk("wrap_ff", bus.o_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    step(); chk("wrap_0", bus.o_cnt, 64'd0);
    step(); chk("wrap_1", bus.o_cnt, 64'd1);
    write_cnt(64'h1234);
    chk("wr_vs_tick", bus.o_cnt, 64'h1234);
    step(); chk("after_wr", bus.o_cnt, 64'h1235);
    bus.i_timer_en = 0;
    step();

    // Compare match, enable gating and clear priority.
    bus.i_cmp_val = 64'd5;
    write_cnt(64'd0);
    bus.i_timer_en = 1;
    step();
    repeat (5) step();
    chk("cnt_at5", bus.o_cnt, 64'd5);
    bus.i_timer_en = 0;
    step();
    chk("int_set", 64'(bus.o_int_st), 64'd1);
    chk("int_gated", 64'(bus.o_tim_int), 64'd0);
    bus.i_int_en = 1;
    #1;
    chk("int_enabled", 64'(bus.o_tim_int), 64'd1);
    bus.i_int_clr = 1;
    step();
    chk("set_wins", 64'(bus.o_int_st), 64'd1);
    bus.i_int_clr = 0;
    write_cnt(64'd7);
    bus.i_int_clr = 1;
    step();
    bus.i_int_clr = 0;
    chk("int_cleared", 64'(bus.o_int_st), 64'd0);
    chk("tim_int_cleared", 64'(bus.o_tim_int), 64'd0);
    bus.i_cmp_val = 64'hDEAD_BEEF_0000_0000;

    // Halt handshake.
    write_cnt(64'd0);
    bus.i_timer_en = 1;
    step();
    repeat (3) step();
    chk("pre_halt", bus.o_cnt, 64'd3);
    bus.i_halt_req = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_ack_hi", 64'(bus.o_halt_ack), 64'd1);
      chk("halt_hold", bus.o_cnt, 64'd3);
    end
    bus.i_halt_req = 0;
    step();
    chk("ack_fall", 64'(bus.o_halt_ack), 64'd0);
    chk("resume_hold", bus.o_cnt, 64'd3);
    step();
    chk("resume_inc", bus.o_cnt, 64'd4);
    bus.i_halt_req = 1;
    step();
    bus.i_timer_en = 0;
    step();
    chk("halt_to_idle", 64'(bus.o_halt_ack), 64'd0);
    bus.i_halt_req = 0;

    // Asynchronous reset with the divider mid-period.
    write_cnt(64'd9);
    bus.i_div_en = 1; bus.i_div_val = 4'd3; bus.i_timer_en = 1; bus.i_cmp_val = 64'd9;
    step();
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_cnt", bus.o_cnt, 64'd0);
    chk("rst_ack", 64'(bus.o_halt_ack), 64'd0);
    chk("rst_int", 64'(bus.o_int_st), 64'd0);
    chk("rst_tim_int", 64'(bus.o_tim_int), 64'd0);
    bus.i_cmp_val = 64'hDEAD_BEEF_0000_0000;
    @(posedge clk);
    #1;
    check_model();
    rst = 1'b0;
    step();
    for (int i = 1; i < 8; i++) step();
    chk("post_rst_no_tick", bus.o_cnt, 64'd0);
    step();
    chk("post_rst_tick8", bus.o_cnt, 64'd1);

    // Randomized segments, each starting from IDLE with a fresh divider setup.
    for (int seg = 0; seg < 24; seg++) begin
      bus.i_timer_en = 0; bus.i_halt_req = 0; bus.i_cnt_wr = 0; bus.i_int_clr = 0;
      bus.i_div_en  = 1'($urandom_range(0, 1));
      bus.i_div_val = 4'($urandom_range(0, 15));
      if (seg % 3 == 0) bus.i_div_val = 4'($urandom_range(0, 2));
      step();
      step();
      bus.i_cmp_val = m_cnt + 64'($urandom_range(0, 24));
      for (int c = 0; c < 70; c++) begin
        bus.i_timer_en = ($urandom_range(0, 15) != 0);
        bus.i_halt_req = ($urandom_range(0, 5) == 0);
        bus.i_cnt_wr   = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 1) == 1)
          bus.i_cnt_wdata = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 4));
        else
          bus.i_cnt_wdata = {$urandom, $urandom};
        bus.i_int_clr = ($urandom_range(0, 4) == 0);
        bus.i_int_en  = 1'($urandom_range(0, 1));
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
